// File: rtl/inst_encoder.sv
// inst_encoder: turns an ALU operation plus register/immediate fields into an
// RV32I instruction word and queues it in a two-entry output buffer.
// Optional feature: define ENCODER_ITYPE_EN to encode use_imm=1 requests as
// OP-IMM (I-type) instructions; without it every use_imm=1 request is illegal.

`ifndef ALU_TYPE_WIDTH
`define ALU_TYPE_WIDTH 4
`endif
`ifndef REG_NUM
`define REG_NUM 5
`endif
`ifndef COMMON_WIDTH
`define COMMON_WIDTH 32
`endif

`ifndef ALU_NOP
`define ALU_NOP  4'd0
`define ALU_ADD  4'd1
`define ALU_SUB  4'd2
`define ALU_SLL  4'd3
`define ALU_SLT  4'd4
`define ALU_SLTU 4'd5
`define ALU_XOR  4'd6
`define ALU_SRL  4'd7
`define ALU_SRA  4'd8
`define ALU_OR   4'd9
`define ALU_AND  4'd10
`endif

// {funct7, funct3}
`ifndef ADD_FUNCT73
`define ADD_FUNCT73  10'b0000000_000
`define SUB_FUNCT73  10'b0100000_000
`define SLL_FUNCT73  10'b0000000_001
`define SLT_FUNCT73  10'b0000000_010
`define SLTU_FUNCT73 10'b0000000_011
`define XOR_FUNCT73  10'b0000000_100
`define SRL_FUNCT73  10'b0000000_101
`define SRA_FUNCT73  10'b0100000_101
`define OR_FUNCT73   10'b0000000_110
`define AND_FUNCT73  10'b0000000_111
`endif

`ifndef POS_OPCODE
`define POS_OPCODE 0
`define POS_RD     7
`define POS_FUNCT3 12
`define POS_RS1    15
`define POS_RS2    20
`define POS_FUNCT7 25
`endif

module inst_encoder (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [`ALU_TYPE_WIDTH-1:0] alu_type,
    input  logic [`REG_NUM-1:0]        rd,
    input  logic [`REG_NUM-1:0]        rs1,
    input  logic [`REG_NUM-1:0]        rs2,
    input  logic                       use_imm,
    input  logic [11:0]                imm,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [`COMMON_WIDTH-1:0]   inst,
    output logic                       illegal,
    output logic                       err_sticky,
    output logic [15:0]                enc_count
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    logic [9:0]  f73;
    logic [6:0]  opcode;
    logic [11:0] upper;
    logic        enc_legal;
    logic [`COMMON_WIDTH-1:0] enc_word;

    logic [1:0]  cnt_q;
    logic [`COMMON_WIDTH-1:0] head_q;
    logic [`COMMON_WIDTH-1:0] tail_q;
    logic        rdy_en_q;
    logic        illegal_q;
    logic        err_q;
    logic [15:0] enc_count_q;

    logic accept;
    logic push;
    logic pop;

    // Field selection: funct7/funct3/opcode and the upper 12 bits
    // (funct7+rs2 for R-type, immediate for I-type).
    always_comb begin
        f73       = 10'b0;
        opcode    = OPC_OP;
        upper     = 12'b0;
        enc_legal = 1'b0;
        if (!use_imm) begin
            enc_legal = 1'b1;
            case (alu_type)
                `ALU_ADD:  f73 = `ADD_FUNCT73;
                `ALU_SUB:  f73 = `SUB_FUNCT73;
                `ALU_SLL:  f73 = `SLL_FUNCT73;
                `ALU_SLT:  f73 = `SLT_FUNCT73;
                `ALU_SLTU: f73 = `SLTU_FUNCT73;
                `ALU_XOR:  f73 = `XOR_FUNCT73;
                `ALU_SRL:  f73 = `SRL_FUNCT73;
                `ALU_SRA:  f73 = `SRA_FUNCT73;
                `ALU_OR:   f73 = `OR_FUNCT73;
                `ALU_AND:  f73 = `AND_FUNCT73;
                default:   enc_legal = 1'b0;
            endcase
            upper = {f73[9:3], rs2};
        end else begin
`ifdef ENCODER_ITYPE_EN
            opcode    = OPC_OP_IMM;
            enc_legal = 1'b1;
            upper     = imm;
            case (alu_type)
                `ALU_ADD:  f73 = `ADD_FUNCT73;
                `ALU_SLT:  f73 = `SLT_FUNCT73;
                `ALU_SLTU: f73 = `SLTU_FUNCT73;
                `ALU_XOR:  f73 = `XOR_FUNCT73;
                `ALU_OR:   f73 = `OR_FUNCT73;
                `ALU_AND:  f73 = `AND_FUNCT73;
                `ALU_SLL: begin
                    f73   = `SLL_FUNCT73;
                    upper = {f73[9:3], imm[4:0]};
                end
                `ALU_SRL: begin
                    f73   = `SRL_FUNCT73;
                    upper = {f73[9:3], imm[4:0]};
                end
                `ALU_SRA: begin
                    f73   = `SRA_FUNCT73;
                    upper = {f73[9:3], imm[4:0]};
                end
                default:   enc_legal = 1'b0;
            endcase
`else
            enc_legal = 1'b0;
`endif
        end
    end

`ifndef ENCODER_ITYPE_EN
    logic unused_imm;
    assign unused_imm = ^imm;
`endif

    // Assemble the instruction word from the selected fields.
    always_comb begin
        enc_word = (`COMMON_WIDTH'(upper)    << `POS_RS2)
                 | (`COMMON_WIDTH'(rs1)      << `POS_RS1)
                 | (`COMMON_WIDTH'(f73[2:0]) << `POS_FUNCT3)
                 | (`COMMON_WIDTH'(rd)       << `POS_RD)
                 | (`COMMON_WIDTH'(opcode)   << `POS_OPCODE);
    end

    // in_ready is held low through reset and until the first clock edge after it.
    assign in_ready  = rdy_en_q && (cnt_q < 2'd2);
    assign out_valid = (cnt_q != 2'd0);
    assign inst      = head_q;
    assign illegal   = illegal_q;
    assign err_sticky = err_q;
    assign enc_count = enc_count_q;

    assign accept = in_valid && in_ready;
    assign push   = accept && enc_legal;
    assign pop    = out_valid && out_ready;

    // Two-entry buffer: head_q is the presented word, tail_q the one behind it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            case (cnt_q)
                2'd0: begin
                    if (push) begin
                        head_q <= enc_word;
                        cnt_q  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_q <= enc_word;
                    end else if (push) begin
                        tail_q <= enc_word;
                        cnt_q  <= 2'd2;
                    end else if (pop) begin
                        cnt_q  <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        head_q <= tail_q;
                        cnt_q  <= 2'd1;
                    end
                end
            endcase
        end
    end

    // Ready enable, illegal pulse, sticky error and saturating delivery count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_en_q    <= 1'b0;
            illegal_q   <= 1'b0;
            err_q       <= 1'b0;
            enc_count_q <= 16'd0;
        end else begin
            rdy_en_q  <= 1'b1;
            illegal_q <= accept && !enc_legal;
            if (accept && !enc_legal) begin
                err_q <= 1'b1;
            end
            if (pop && (enc_count_q != 16'hFFFF)) begin
                enc_count_q <= enc_count_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder with a scoreboard queue of expected words.
module tb_inst_encoder;

    localparam logic [3:0] A_NOP  = 4'd0;
    localparam logic [3:0] A_ADD  = 4'd1;
    localparam logic [3:0] A_SUB  = 4'd2;
    localparam logic [3:0] A_SLL  = 4'd3;
    localparam logic [3:0] A_SLT  = 4'd4;
    localparam logic [3:0] A_SLTU = 4'd5;
    localparam logic [3:0] A_XOR  = 4'd6;
    localparam logic [3:0] A_SRL  = 4'd7;
    localparam logic [3:0] A_SRA  = 4'd8;
    localparam logic [3:0] A_OR   = 4'd9;
    localparam logic [3:0] A_AND  = 4'd10;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_type;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        use_imm;
    logic [11:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] inst;
    logic        illegal;
    logic        err_sticky;
    logic [15:0] enc_count;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [15:0] exp_cnt = 16'd0;
    logic        cur_ok;
    logic [31:0] cur_w;

    inst_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_type   (alu_type),
        .rd         (rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .use_imm    (use_imm),
        .imm        (imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .inst       (inst),
        .illegal    (illegal),
        .err_sticky (err_sticky),
        .enc_count  (enc_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void ref_enc(input logic [3:0] a, input logic [4:0] d,
                                    input logic [4:0] s1, input logic [4:0] s2,
                                    input logic ui, input logic [11:0] im,
                                    output logic ok, output logic [31:0] w);
        logic [6:0] f7;
        logic [2:0] f3;
        logic [11:0] hi;
        ok = 1'b1;
        f7 = 7'd0;
        f3 = 3'd0;
        w  = 32'd0;
        if (!ui) begin
            case (a)
                A_ADD:  f3 = 3'b000;
                A_SUB:  begin f7 = 7'b0100000; f3 = 3'b000; end
                A_SLL:  f3 = 3'b001;
                A_SLT:  f3 = 3'b010;
                A_SLTU: f3 = 3'b011;
                A_XOR:  f3 = 3'b100;
                A_SRL:  f3 = 3'b101;
                A_SRA:  begin f7 = 7'b0100000; f3 = 3'b101; end
                A_OR:   f3 = 3'b110;
                A_AND:  f3 = 3'b111;
                default: ok = 1'b0;
            endcase
            w = {f7, s2, s1, f3, d, 7'b0110011};
        end else begin
`ifdef ENCODER_ITYPE_EN
            hi = im;
            case (a)
                A_ADD:  f3 = 3'b000;
                A_SLT:  f3 = 3'b010;
                A_SLTU: f3 = 3'b011;
                A_XOR:  f3 = 3'b100;
                A_OR:   f3 = 3'b110;
                A_AND:  f3 = 3'b111;
                A_SLL:  begin f3 = 3'b001; hi = {7'b0000000, im[4:0]}; end
                A_SRL:  begin f3 = 3'b101; hi = {7'b0000000, im[4:0]}; end
                A_SRA:  begin f3 = 3'b101; hi = {7'b0100000, im[4:0]}; end
                default: ok = 1'b0;
            endcase
            w = {hi, s1, f3, d, 7'b0010011};
`else
            hi = im;
            ok = 1'b0;
            w  = {hi, 20'd0};
`endif
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [3:0] a, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic ui, input logic [11:0] im);
        in_valid = 1'b1;
        alu_type = a;
        rd       = d;
        rs1      = s1;
        rs2      = s2;
        use_imm  = ui;
        imm      = im;
        ref_enc(a, d, s1, s2, ui, im, cur_ok, cur_w);
    endtask

    // Score the handshakes that will happen on the coming edge, then advance.
    task automatic tick();
        logic [31:0] e;
        if (out_valid && out_ready) begin
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_inst", inst, e);
            end
            exp_cnt = exp_cnt + 16'd1;
        end
        if (in_valid && in_ready && cur_ok) begin
            exp_q.push_back(cur_w);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_type  = A_NOP;
        rd        = 5'd0;
        rs1       = 5'd0;
        rs2       = 5'd0;
        use_imm   = 1'b0;
        imm       = 12'd0;
        cur_ok    = 1'b0;
        cur_w     = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_err_sticky", 32'(err_sticky), 32'd0);
        check("rst_enc_count", 32'(enc_count), 32'd0);
        rst = 1'b0;
        tick();
        check("ready_after_rst", 32'(in_ready), 32'd1);

        // ADD x3, x1, x2 with consumer ready
        out_ready = 1'b1;
        req(A_ADD, 5'd3, 5'd1, 5'd2, 1'b0, 12'd0);
        tick();
        in_valid = 1'b0;
        check("add_valid", 32'(out_valid), 32'd1);
        check("add_inst", inst, 32'h002081B3);
        tick();
        check("add_count", 32'(enc_count), 32'd1);
        check("add_drained", 32'(out_valid), 32'd0);

        // SUB x5, x6, x7 held while consumer stalls
        out_ready = 1'b0;
        req(A_SUB, 5'd5, 5'd6, 5'd7, 1'b0, 12'd0);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("sub_hold_valid", 32'(out_valid), 32'd1);
            check("sub_hold_inst", inst, 32'h407302B3);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("sub_drained", 32'(out_valid), 32'd0);
        check("sub_count", 32'(enc_count), 32'(exp_cnt));

        // Immediate forms
        req(A_ADD, 5'd1, 5'd0, 5'd0, 1'b1, 12'd5);
        tick();
        in_valid = 1'b0;
`ifdef ENCODER_ITYPE_EN
        check("addi_valid", 32'(out_valid), 32'd1);
        check("addi_inst", inst, 32'h00500093);
        check("addi_illegal", 32'(illegal), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
`else
        check("addi_illegal", 32'(illegal), 32'd1);
        check("addi_err", 32'(err_sticky), 32'd1);
        check("addi_no_valid", 32'(out_valid), 32'd0);
        tick();
        check("addi_pulse_end", 32'(illegal), 32'd0);
`endif
        req(A_SRA, 5'd4, 5'd4, 5'd0, 1'b1, 12'd3);
        tick();
        in_valid = 1'b0;
`ifdef ENCODER_ITYPE_EN
        check("srai_inst", inst, 32'h40325213);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        req(A_SUB, 5'd1, 5'd2, 5'd0, 1'b1, 12'd1);
        tick();
        in_valid = 1'b0;
        check("subi_illegal", 32'(illegal), 32'd1);
        check("subi_no_valid", 32'(out_valid), 32'd0);
`else
        check("srai_illegal", 32'(illegal), 32'd1);
        check("srai_no_valid", 32'(out_valid), 32'd0);
`endif
        tick();
        check("imm_err_sticky", 32'(err_sticky), 32'd1);

        // Simultaneous push and pop at occupancy 1
        req(A_SLL, 5'd9, 5'd10, 5'd11, 1'b0, 12'd0);
        tick();
        req(A_SLT, 5'd12, 5'd13, 5'd14, 1'b0, 12'd0);
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("pp_valid", 32'(out_valid), 32'd1);
        check("pp_ready", 32'(in_ready), 32'd1);
        check("pp_head", inst, exp_q[0]);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("pp_drained", 32'(out_valid), 32'd0);

        // Fill, back-pressure and ordering
        req(A_XOR, 5'd1, 5'd2, 5'd3, 1'b0, 12'd0);
        tick();
        check("fill1_ready", 32'(in_ready), 32'd1);
        req(A_OR, 5'd4, 5'd5, 5'd6, 1'b0, 12'd0);
        tick();
        check("fill2_ready", 32'(in_ready), 32'd0);
        check("fill2_head", inst, exp_q[0]);
        req(A_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 12'd0);
        tick();
        check("full_nop_ignored", 32'(illegal), 32'd0);
        req(A_AND, 5'd7, 5'd8, 5'd9, 1'b0, 12'd0);
        tick();
        check("full_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("after_pop_ready", 32'(in_ready), 32'd1);
        check("after_pop_head", inst, exp_q[0]);
        tick();
        in_valid = 1'b0;
        check("refill_ready", 32'(in_ready), 32'd0);
        check("fifo_depth", 32'(exp_q.size()), 32'd2);
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        check("order_drained", 32'(out_valid), 32'd0);
        check("order_count", 32'(enc_count), 32'(exp_cnt));

        // More R-type forms through the scoreboard
        out_ready = 1'b1;
        req(A_SRL, 5'd31, 5'd30, 5'd29, 1'b0, 12'd0);
        tick();
        req(A_SLTU, 5'd17, 5'd18, 5'd19, 1'b0, 12'd0);
        tick();
        req(A_SRA, 5'd20, 5'd21, 5'd22, 1'b0, 12'd0);
        tick();
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        check("rtype_drained", 32'(out_valid), 32'd0);

        // NOP and unlisted codes are illegal one-cycle pulses
        req(A_NOP, 5'd1, 5'd1, 5'd1, 1'b0, 12'd0);
        tick();
        in_valid = 1'b0;
        check("nop_illegal", 32'(illegal), 32'd1);
        check("nop_err", 32'(err_sticky), 32'd1);
        check("nop_count", 32'(enc_count), 32'(exp_cnt));
        check("nop_no_valid", 32'(out_valid), 32'd0);
        tick();
        check("nop_pulse_end", 32'(illegal), 32'd0);
        check("nop_err_hold", 32'(err_sticky), 32'd1);
        req(4'd15, 5'd2, 5'd3, 5'd4, 1'b0, 12'd0);
        tick();
        in_valid = 1'b0;
        check("bad_code_illegal", 32'(illegal), 32'd1);
        tick();

        // Asynchronous reset with two entries buffered
        req(A_ADD, 5'd1, 5'd2, 5'd3, 1'b0, 12'd0);
        tick();
        req(A_AND, 5'd4, 5'd5, 5'd6, 1'b0, 12'd0);
        tick();
        in_valid = 1'b0;
        check("pre_rst_full", 32'(in_ready), 32'd0);
        #3;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_enc_count", 32'(enc_count), 32'd0);
        check("arst_err_sticky", 32'(err_sticky), 32'd0);
        check("arst_inst", inst, 32'd0);
        exp_q.delete();
        exp_cnt = 16'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        check("arst_ready", 32'(in_ready), 32'd1);
        check("sb_empty_end", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
